// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: miss handler between a direct-mapped cache and memory.
// Writes back a dirty victim line, fetches the missed line, then pulses fill_valid.
`default_nettype none

module cache_refill_ctrl #(
    parameter int ACCESS_LENGTH = 8,
    parameter int LINE_LENGTH   = 32,
    parameter int ADDRESS_SIZE  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     miss,
    input  logic [ADDRESS_SIZE-1:0]  miss_addr,
    input  logic                     victim_dirty,
    input  logic [ADDRESS_SIZE-1:0]  victim_addr,
    input  logic [LINE_LENGTH-1:0]   victim_data,
    output logic                     busy,
    output logic                     fill_valid,
    output logic [LINE_LENGTH-1:0]   fill_data,
    output logic                     mem_req,
    output logic                     mem_write,
    output logic [ADDRESS_SIZE-1:0]  mem_addr,
    output logic [ACCESS_LENGTH-1:0] mem_wdata,
    input  logic [ACCESS_LENGTH-1:0] mem_rdata,
    input  logic                     mem_ack
);

    localparam int BEATS = LINE_LENGTH / ACCESS_LENGTH;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ADDRESS_SIZE-1:0] BEAT_MASK = ADDRESS_SIZE'(BEATS - 1);
    localparam logic [CW-1:0]           LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WB    = 2'd1,
        S_FETCH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [ADDRESS_SIZE-1:0]    miss_base_q, miss_base_d;
    logic [ADDRESS_SIZE-1:0]    vic_base_q, vic_base_d;
    logic [LINE_LENGTH-1:0]     vic_data_q, vic_data_d;
    logic [LINE_LENGTH-1:0]     fill_q, fill_d;
    logic                       busy_q, busy_d;
    logic                       fill_valid_q, fill_valid_d;
    logic                       mem_req_q, mem_req_d;
    logic                       mem_write_q, mem_write_d;
    logic [ADDRESS_SIZE-1:0]    mem_addr_q, mem_addr_d;
    logic [ACCESS_LENGTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic                       ack;

    assign ack = mem_req_q & mem_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            miss_base_q  <= '0;
            vic_base_q   <= '0;
            vic_data_q   <= '0;
            fill_q       <= '0;
            busy_q       <= 1'b0;
            fill_valid_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            miss_base_q  <= miss_base_d;
            vic_base_q   <= vic_base_d;
            vic_data_q   <= vic_data_d;
            fill_q       <= fill_d;
            busy_q       <= busy_d;
            fill_valid_q <= fill_valid_d;
            mem_req_q    <= mem_req_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        miss_base_d = miss_base_q;
        vic_base_d  = vic_base_q;
        vic_data_d  = vic_data_q;
        fill_d      = fill_q;

        case (state_q)
            S_IDLE: begin
                if (miss) begin
                    miss_base_d = miss_addr & ~BEAT_MASK;
                    cnt_d       = '0;
                    if (victim_dirty) begin
                        vic_base_d = victim_addr & ~BEAT_MASK;
                        vic_data_d = victim_data;
                        state_d    = S_WB;
                    end else begin
                        state_d    = S_FETCH;
                    end
                end
            end
            S_WB: begin
                if (ack) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = S_FETCH;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_FETCH: begin
                if (ack) begin
                    // Beat 0 lands in the most significant slot of the line.
                    for (int k = 0; k < BEATS; k++) begin
                        if (cnt_q == CW'(k))
                            fill_d[LINE_LENGTH-1-k*ACCESS_LENGTH -: ACCESS_LENGTH] = mem_rdata;
                    end
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so that they leave a flop.
        busy_d       = (state_d != S_IDLE);
        fill_valid_d = (state_d == S_DONE);
        mem_req_d    = (state_d == S_WB) || (state_d == S_FETCH);
        mem_write_d  = (state_d == S_WB);
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        if (state_d == S_WB) begin
            mem_addr_d = vic_base_d | ADDRESS_SIZE'(cnt_d);
            for (int k = 0; k < BEATS; k++) begin
                if (cnt_d == CW'(k))
                    mem_wdata_d = vic_data_d[LINE_LENGTH-1-k*ACCESS_LENGTH -: ACCESS_LENGTH];
            end
        end else if (state_d == S_FETCH) begin
            mem_addr_d = miss_base_d | ADDRESS_SIZE'(cnt_d);
        end
    end

    assign busy       = busy_q;
    assign fill_valid = fill_valid_q;
    assign fill_data  = fill_q;
    assign mem_req    = mem_req_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: randomized bench for cache_refill_ctrl with a memory
// model and a line-level reference for beat order, latency and fill data.
`default_nettype none

module tb_cache_refill_ctrl;

    localparam int A  = 8;
    localparam int L  = 32;
    localparam int AS = 8;
    localparam int B  = L / A;

    logic          clk = 1'b0;
    logic          reset;
    logic          miss;
    logic [AS-1:0] miss_addr;
    logic          victim_dirty;
    logic [AS-1:0] victim_addr;
    logic [L-1:0]  victim_data;
    logic          busy;
    logic          fill_valid;
    logic [L-1:0]  fill_data;
    logic          mem_req;
    logic          mem_write;
    logic [AS-1:0] mem_addr;
    logic [A-1:0]  mem_wdata;
    logic [A-1:0]  mem_rdata;
    logic          mem_ack;

    int n_checks = 0;
    int n_errors = 0;

    logic [A-1:0] mem_arr [256];
    logic [L-1:0] last_fill;

    cache_refill_ctrl #(.ACCESS_LENGTH(A), .LINE_LENGTH(L), .ADDRESS_SIZE(AS)) dut (
        .clk(clk), .reset(reset), .miss(miss), .miss_addr(miss_addr),
        .victim_dirty(victim_dirty), .victim_addr(victim_addr), .victim_data(victim_data),
        .busy(busy), .fill_valid(fill_valid), .fill_data(fill_data),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One miss transaction. waitmode < 0: random 0..3 wait cycles per beat,
    // otherwise a fixed count. abort_at >= 0: assert reset while that WB beat is presented.
    task automatic do_miss(input logic [AS-1:0] maddr, input logic dirty,
                           input logic [AS-1:0] vaddr, input logic [L-1:0] vdata,
                           input int waitmode, input int abort_at);
        logic [AS-1:0] e_addr [2*B];
        logic          e_wr   [2*B];
        logic [A-1:0]  e_wd   [2*B];
        logic [L-1:0]  e_fill;
        logic [AS-1:0] mbase, vbase;
        int n, idx, wleft, waits, cyc;
        mbase = maddr & ~AS'(B - 1);
        vbase = vaddr & ~AS'(B - 1);
        n = 0;
        e_fill = '0;
        if (dirty) begin
            for (int k = 0; k < B; k++) begin
                e_addr[n] = vbase + AS'(k);
                e_wr[n]   = 1'b1;
                e_wd[n]   = vdata[L-1-k*A -: A];
                n++;
            end
        end
        for (int k = 0; k < B; k++) begin
            e_addr[n] = mbase + AS'(k);
            e_wr[n]   = 1'b0;
            e_wd[n]   = '0;
            e_fill    = (e_fill << A) | L'((dirty && vbase == mbase) ? vdata[L-1-k*A -: A]
                                                                    : mem_arr[mbase + AS'(k)]);
            n++;
        end

        miss = 1'b1; miss_addr = maddr; victim_dirty = dirty;
        victim_addr = vaddr; victim_data = vdata; mem_ack = 1'b0;
        idx = 0; wleft = -1; waits = 0; cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            // Noise on the miss port while busy must not start a new request.
            miss         = ($urandom_range(0, 2) == 0);
            miss_addr    = 8'h40;
            victim_dirty = $urandom_range(0, 1) != 0;
            victim_addr  = AS'($urandom);
            victim_data  = L'($urandom);
            mem_rdata    = A'($urandom);
            if (cyc > 300) begin
                chk("timeout", 64'(cyc), 64'(0));
                mem_ack = 1'b0; miss = 1'b0;
                return;
            end
            if (fill_valid) begin
                chk("fill_latency", 64'(cyc), 64'(n + 1 + waits));
                chk("beats_done", 64'(idx), 64'(n));
                chk("fill_data", 64'(fill_data), 64'(e_fill));
                chk("done_req", 64'(mem_req), 64'(0));
                last_fill = e_fill;
                miss = 1'b1;                 // sampled in DONE: must be ignored
                mem_ack = 1'b1;
                @(negedge clk);
                chk("idle_after_done_busy", 64'(busy), 64'(0));
                chk("idle_after_done_req", 64'(mem_req), 64'(0));
                chk("fill_pulse_width", 64'(fill_valid), 64'(0));
                miss = 1'b0; mem_ack = 1'b0;
                return;
            end
            chk("busy", 64'(busy), 64'(1));
            if (!mem_req) begin
                chk("req_gap", 64'(idx), 64'(n));
                mem_ack = ($urandom_range(0, 1) != 0);
                continue;
            end
            if (idx >= n) begin
                chk("extra_beat", 64'(idx), 64'(n - 1));
                mem_ack = 1'b1;
                continue;
            end
            chk("mem_addr", 64'(mem_addr), 64'(e_addr[idx]));
            chk("mem_write", 64'(mem_write), 64'(e_wr[idx]));
            if (e_wr[idx]) chk("mem_wdata", 64'(mem_wdata), 64'(e_wd[idx]));
            if (abort_at >= 0 && dirty && idx == abort_at) begin
                reset = 1'b0;
                #1;
                chk("abort_busy", 64'(busy), 64'(0));
                chk("abort_req", 64'(mem_req), 64'(0));
                chk("abort_fill_valid", 64'(fill_valid), 64'(0));
                chk("abort_fill_data", 64'(fill_data), 64'(0));
                last_fill = '0;
                mem_ack = 1'b0; miss = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            if (wleft < 0) wleft = (waitmode < 0) ? int'($urandom_range(0, 3)) : waitmode;
            if (wleft == 0) begin
                mem_ack = 1'b1;
                if (mem_write) mem_arr[mem_addr] = mem_wdata;
                else           mem_rdata = mem_arr[mem_addr];
                idx++;
                wleft = -1;
            end else begin
                mem_ack = 1'b0;
                wleft--;
                waits++;
            end
        end
    endtask

    task automatic idle_cycles(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            miss = 1'b0;
            mem_ack = 1'b1;                  // spurious ack while idle
            mem_rdata = A'($urandom);
            @(negedge clk);
            chk("idle_busy", 64'(busy), 64'(0));
            chk("idle_req", 64'(mem_req), 64'(0));
            chk("idle_fill_data", 64'(fill_data), 64'(last_fill));
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = A'($urandom);
        mem_arr[8'h24] = 8'h11; mem_arr[8'h25] = 8'h22;
        mem_arr[8'h26] = 8'h33; mem_arr[8'h27] = 8'h44;
        reset = 1'b0; miss = 1'b0; miss_addr = '0; victim_dirty = 1'b0;
        victim_addr = '0; victim_data = '0; mem_rdata = '0; mem_ack = 1'b0;
        last_fill = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_fill_valid", 64'(fill_valid), 64'(0));
        chk("rst_req", 64'(mem_req), 64'(0));
        chk("rst_write", 64'(mem_write), 64'(0));
        chk("rst_addr", 64'(mem_addr), 64'(0));
        chk("rst_wdata", 64'(mem_wdata), 64'(0));
        chk("rst_fill_data", 64'(fill_data), 64'(0));
        reset = 1'b1;
        @(negedge clk);

        do_miss(8'h25, 1'b0, 8'h99, 32'h0BAD_F00D, 0, -1);
        chk("clean_fill_const", 64'(last_fill), 64'h1122_3344);
        idle_cycles(3);
        do_miss(8'h10, 1'b1, 8'h80, 32'hDEAD_BEEF, 0, -1);
        chk("wb_mem_80", 64'(mem_arr[8'h80]), 64'hDE);
        chk("wb_mem_83", 64'(mem_arr[8'h83]), 64'hEF);
        idle_cycles(2);
        do_miss(8'h25, 1'b0, 8'h00, 32'h0, 3, -1);
        chk("wait_fill_const", 64'(last_fill), 64'h1122_3344);
        idle_cycles(1);
        do_miss(8'h40, 1'b1, 8'hC1, 32'hCAFE_1234, -1, 2);
        idle_cycles(2);
        do_miss(8'h08, 1'b0, 8'h00, 32'h0, 0, -1);
        idle_cycles(1);

        for (int t = 0; t < 40; t++) begin
            do_miss(AS'($urandom), $urandom_range(0, 1) != 0, AS'($urandom), L'($urandom), -1, -1);
            idle_cycles(int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
